daa_target: RTL
===============

DAA_TARGET -- requirements
Module: daa_target

Interface
REQ-001 i_clk  in  1  system clock; all logic on rising edge.
REQ-002 i_reset_n  in  1  asynchronous active-low reset.
REQ-003 i_enable  in  1  level; ENTDAA CCC already decoded, block participates while high.
REQ-004 i_scl, i_sda  in  1 each  bus levels, already synchronised to i_clk.
REQ-005 o_sda_low  out  1  1 pulls SDA low (open-drain); 0 releases.
REQ-006 i_pid_bcr_dcr  in  64  provisioned ID, sent MSB first; sampled when a header is accepted.
REQ-007 i_has_da  in  1  target already owns a dynamic address; block stays idle.
REQ-008 o_da  out  7  assigned dynamic address; holds until the next assignment.
REQ-009 o_da_valid  out  1  one-cycle pulse when o_da is updated.
REQ-010 o_lost  out  1  one-cycle pulse on arbitration loss.
REQ-011 o_error  out  1  one-cycle pulse on DA parity failure.
REQ-012 o_busy  out  1  high in every state except IDLE and DONE.

Function
REQ-013 Edge detection: prev-sample registers on SCL/SDA; scl_rise, scl_fall; START/Sr = SDA 1->0 with SCL high in both samples; STOP = SDA 0->1 with SCL high in both samples.
REQ-014 States: IDLE, WAIT_SR, HEADER, HDR_ACK, PID, DA, DA_ACK, DONE; 6-bit bit counter; 64-bit shift register.
REQ-015 IDLE -> WAIT_SR when i_enable=1 and i_has_da=0.
REQ-016 i_enable=0 in any state -> IDLE next cycle, o_sda_low=0.
REQ-017 START/Sr in WAIT_SR, HEADER, HDR_ACK, PID, DA or DA_ACK -> HEADER, counter=0, SDA released.
REQ-018 STOP in any state other than IDLE or DONE -> WAIT_SR; STOP in DONE has no effect.
REQ-019 HEADER: shift SDA on each scl_rise; after the 8th bit, byte 8'hFD (7E/R) -> HDR_ACK and latch i_pid_bcr_dcr; any other byte -> WAIT_SR, no ACK.
REQ-020 HDR_ACK: o_sda_low=1 from the first scl_fall until the next scl_fall, then -> PID with bit 63 driven on that same fall.
REQ-021 PID: on each scl_fall, drive the next bit (0 -> o_sda_low=1, 1 -> release).
REQ-022 PID: on each scl_rise, if the driven bit is 1 and SDA samples 0, pulse o_lost, release SDA and -> WAIT_SR.
REQ-023 PID: after the 64th scl_rise without loss, release SDA on the next scl_fall and -> DA.
REQ-024 DA: sample 8 bits on scl_rise, MSB first: DA[6:0], then parity P.
REQ-025 Parity is valid when P == ~^DA[6:0] (odd parity).
REQ-026 DA, parity valid -> DA_ACK: o_sda_low=1 from the next scl_fall to the following scl_fall, then release, latch o_da, pulse o_da_valid, -> DONE.
REQ-027 DA, parity invalid -> release SDA (NACK), pulse o_error, -> WAIT_SR.
REQ-028 DONE: bus ignored; leaves only via i_enable=0.
REQ-029 Change o_sda_low only on scl_fall, except on loss, START, STOP or disable, which release it immediately.
REQ-030 Latency: o_sda_low changes 1 cycle after the scl_fall detection cycle; o_lost, o_error and o_da_valid assert 1 cycle after the deciding edge is detected.

Reset
REQ-031 Asynchronous assertion: state=IDLE, counter=0, shift register=0, o_sda_low=0, o_da=7'h00, o_da_valid=o_lost=o_error=0, o_busy=0, edge registers=1 (bus idle high).
REQ-032 Release is synchronous to i_clk; the first START is detected no earlier than 2 cycles after release.
REQ-033 Reset mid-transfer releases SDA within the reset assertion, with no glitch low.

Structure
REQ-034 Shared package i3c_target_pkg: state enum, ENTDAA_HDR=8'hFD, PID_BITS=64, DA_BITS=7.
REQ-035 One sub-module bus_cond_detect (SCL/SDA edge, START and STOP detection), reused by other target blocks.

Verification
REQ-036 Enable, Sr+0xFD, no contender, controller sends DA=7'h08 with P=0 -> ACK on both ACK slots, PID 64'hDEADBEEFBEEFDEAD on SDA, o_da=7'h08, one o_da_valid pulse, DONE.
REQ-037 Contender pulls SDA low at PID bit 63 while we send 1 -> o_lost pulse in that bit, SDA released, state WAIT_SR; next Sr+0xFD -> target ACKs and arbitrates again.
REQ-038 DA=7'h08 with P=1 -> no ACK on the 9th bit, o_error pulse, o_da unchanged (7'h00).
REQ-039 Header 0xFC -> no ACK, WAIT_SR; i_has_da=1 -> no SDA activity for the whole ENTDAA.
REQ-040 i_reset_n low at PID bit 20 while o_sda_low=1 -> o_sda_low=0 immediately, all outputs at reset values; i_enable drop mid-DA -> IDLE next cycle.

Source files
------------

// File: rtl/i3c_target_pkg.sv
// Shared definitions for the I3C target-side blocks: ENTDAA constants,
// the dynamic-address-assignment state type and the DA parity rule.
package i3c_target_pkg;

    localparam logic [7:0] ENTDAA_HDR = 8'hFD;
    localparam int         PID_BITS   = 64;
    localparam int         DA_BITS    = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_SR,
        ST_HEADER,
        ST_HDR_ACK,
        ST_PID,
        ST_DA,
        ST_DA_ACK,
        ST_DONE
    } daa_state_t;

    // Received DA byte is {DA[6:0], P}; P must make DA odd parity.
    function automatic logic da_parity_ok(input logic [7:0] rx);
        return rx[0] == ~^rx[7:1];
    endfunction

endpackage

// File: rtl/bus_cond_detect.sv
// SCL/SDA edge and START/STOP condition detector on pre-synchronised bus
// levels. Previous-sample registers reset high (idle bus); START/STOP are
// suppressed for the first cycle after reset so stale levels cannot fake one.
module bus_cond_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic scl_q;
    logic sda_q;
    logic armed;

    // Previous-sample registers plus a one-shot arm flag after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
            armed <= 1'b0;
        end else begin
            scl_q <= scl;
            sda_q <= sda;
            armed <= 1'b1;
        end
    end

    assign scl_rise = armed &  scl & ~scl_q;
    assign scl_fall = armed & ~scl &  scl_q;
    assign start    = armed & scl & scl_q &  sda_q & ~sda;
    assign stop     = armed & scl & scl_q & ~sda_q &  sda;

endmodule

// File: rtl/daa_target.sv
// ENTDAA target: answers the 7E/R header, arbitrates its 64-bit provisioned
// ID onto SDA, then receives and ACKs a dynamic address.
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | not participating (disabled or already owns a DA)
// WAIT_SR    | waiting for START / repeated START
// HEADER     | receiving the 8-bit header
// HDR_ACK    | driving the header ACK (phase 0: wait fall, 1: ACK low)
// PID        | sending PID/BCR/DCR MSB first, checking for arbitration loss
// DA         | receiving DA[6:0] + parity
// DA_ACK     | driving the DA ACK (phase 0: wait fall, 1: ACK low)
// DONE       | address assigned, bus ignored until disabled
module daa_target
    import i3c_target_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_enable,
    input  logic                i_scl,
    input  logic                i_sda,
    output logic                o_sda_low,
    input  logic [PID_BITS-1:0] i_pid_bcr_dcr,
    input  logic                i_has_da,
    output logic [DA_BITS-1:0]  o_da,
    output logic                o_da_valid,
    output logic                o_lost,
    output logic                o_error,
    output logic                o_busy
);

    logic scl_rise, scl_fall, start, stop;

    daa_state_t          state_q, state_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [PID_BITS-1:0] sr_q, sr_d;
    logic                phase_q, phase_d;
    logic                sda_low_d;
    logic [DA_BITS-1:0]  da_d;
    logic                da_valid_d, lost_d, error_d;
    logic [7:0]          rx_byte;

    bus_cond_detect u_cond (
        .clk      (i_clk),
        .rst_n    (i_reset_n),
        .scl      (i_scl),
        .sda      (i_sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    // State, datapath and registered outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sr_q       <= '0;
            phase_q    <= 1'b0;
            o_sda_low  <= 1'b0;
            o_da       <= '0;
            o_da_valid <= 1'b0;
            o_lost     <= 1'b0;
            o_error    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            phase_q    <= phase_d;
            o_sda_low  <= sda_low_d;
            o_da       <= da_d;
            o_da_valid <= da_valid_d;
            o_lost     <= lost_d;
            o_error    <= error_d;
        end
    end

    // Next-state and next-output decode; disable, then START/STOP, take priority.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        phase_d    = phase_q;
        sda_low_d  = o_sda_low;
        da_d       = o_da;
        da_valid_d = 1'b0;
        lost_d     = 1'b0;
        error_d    = 1'b0;
        rx_byte    = {sr_q[6:0], i_sda};

        if (!i_enable) begin
            state_d   = ST_IDLE;
            sda_low_d = 1'b0;
        end else if (state_q != ST_IDLE && state_q != ST_DONE && (start || stop)) begin
            state_d   = start ? ST_HEADER : ST_WAIT_SR;
            cnt_d     = '0;
            phase_d   = 1'b0;
            sda_low_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!i_has_da) state_d = ST_WAIT_SR;
                end
                ST_HEADER: begin
                    if (scl_rise) begin
                        sr_d  = {sr_q[PID_BITS-2:0], i_sda};
                        cnt_d = cnt_q + 6'd1;
                        if (cnt_q == 6'd7) begin
                            cnt_d = '0;
                            if (rx_byte == ENTDAA_HDR) begin
                                state_d = ST_HDR_ACK;
                                sr_d    = i_pid_bcr_dcr;
                                phase_d = 1'b0;
                            end else begin
                                state_d = ST_WAIT_SR;
                            end
                        end
                    end
                end
                ST_HDR_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_low_d = 1'b1;
                            phase_d   = 1'b1;
                        end else begin
                            sda_low_d = ~sr_q[PID_BITS-1];
                            phase_d   = 1'b0;
                            cnt_d     = '0;
                            state_d   = ST_PID;
                        end
                    end
                end
                ST_PID: begin
                    // phase 1 marks "all 64 bits sent, release on next fall"
                    if (scl_rise && !phase_q) begin
                        if (sr_q[PID_BITS-1] && !i_sda) begin
                            lost_d    = 1'b1;
                            sda_low_d = 1'b0;
                            state_d   = ST_WAIT_SR;
                        end else begin
                            sr_d  = sr_q << 1;
                            cnt_d = cnt_q + 6'd1;
                            if (cnt_q == 6'(PID_BITS - 1)) phase_d = 1'b1;
                        end
                    end else if (scl_fall) begin
                        if (phase_q) begin
                            sda_low_d = 1'b0;
                            phase_d   = 1'b0;
                            cnt_d     = '0;
                            state_d   = ST_DA;
                        end else begin
                            sda_low_d = ~sr_q[PID_BITS-1];
                        end
                    end
                end
                ST_DA: begin
                    if (scl_rise) begin
                        sr_d  = {sr_q[PID_BITS-2:0], i_sda};
                        cnt_d = cnt_q + 6'd1;
                        if (cnt_q == 6'd7) begin
                            cnt_d = '0;
                            if (da_parity_ok(rx_byte)) begin
                                state_d = ST_DA_ACK;
                                phase_d = 1'b0;
                            end else begin
                                error_d   = 1'b1;
                                sda_low_d = 1'b0;
                                state_d   = ST_WAIT_SR;
                            end
                        end
                    end
                end
                ST_DA_ACK: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            sda_low_d = 1'b1;
                            phase_d   = 1'b1;
                        end else begin
                            sda_low_d  = 1'b0;
                            phase_d    = 1'b0;
                            da_d       = sr_q[7:1];
                            da_valid_d = 1'b1;
                            state_d    = ST_DONE;
                        end
                    end
                end
                ST_WAIT_SR, ST_DONE: begin
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign o_busy = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule
